// File: rtl/multicycle_alu.sv
// multicycle_alu: registered, handshaked ALU for the multicycle datapath.
//   Logic, shift, compare and add/sub finish one cycle after start. MULU is
//   an iterative shift-add multiply. DIVU is an iterative restoring divide,
//   built only when the MCALU_DIV_EN macro is defined. Without the macro,
//   opcode 1100 behaves like any unknown opcode.
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   start              op request, sampled only in IDLE
//   ALUsel             opcode
//   ALUIn1, ALUIn2     operands A and B
//   shamt              immediate shift amount
//   ALUOut, ALUOutHi   result low/high word (quotient/remainder for DIVU)
//   Zero               ALUOut == 0, registered with the result
//   divzero            last op was DIVU with B == 0
//   busy               high in MUL/DIV
//   done               one-cycle pulse when a result is written
module multicycle_alu #(
  parameter int WL  = 32,
  parameter int SHW = 5,
  parameter int SEL = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [SEL-1:0] ALUsel,
  input  logic [WL-1:0]  ALUIn1,
  input  logic [WL-1:0]  ALUIn2,
  input  logic [SHW-1:0] shamt,
  output logic [WL-1:0]  ALUOut,
  output logic [WL-1:0]  ALUOutHi,
  output logic           Zero,
  output logic           divzero,
  output logic           busy,
  output logic           done
);

  localparam logic [SEL-1:0] OP_AND  = SEL'(4'b0000);
  localparam logic [SEL-1:0] OP_OR   = SEL'(4'b0001);
  localparam logic [SEL-1:0] OP_ADD  = SEL'(4'b0010);
  localparam logic [SEL-1:0] OP_SLL  = SEL'(4'b0011);
  localparam logic [SEL-1:0] OP_SRL  = SEL'(4'b0100);
  localparam logic [SEL-1:0] OP_SRA  = SEL'(4'b0101);
  localparam logic [SEL-1:0] OP_SUB  = SEL'(4'b0110);
  localparam logic [SEL-1:0] OP_SLTU = SEL'(4'b0111);
  localparam logic [SEL-1:0] OP_SLLV = SEL'(4'b1000);
  localparam logic [SEL-1:0] OP_SRLV = SEL'(4'b1001);
  localparam logic [SEL-1:0] OP_SRAV = SEL'(4'b1010);
  localparam logic [SEL-1:0] OP_MULU = SEL'(4'b1011);
  localparam logic [SEL-1:0] OP_SLT  = SEL'(4'b1101);
`ifdef MCALU_DIV_EN
  localparam logic [SEL-1:0] OP_DIVU = SEL'(4'b1100);
`endif
  localparam logic [SHW-1:0] CNT_LAST = SHW'(WL - 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t         state_q, state_d;
  logic [SHW-1:0] cnt_q, cnt_d;
  // op_q: multiplicand for MULU, divisor for DIVU.
  // work_hi/lo: partial product, or partial remainder and dividend/quotient.
  logic [WL-1:0]  op_q, op_d;
  logic [WL-1:0]  work_hi_q, work_hi_d;
  logic [WL-1:0]  work_lo_q, work_lo_d;
  logic [WL-1:0]  alu_out_q, alu_out_d;
  logic [WL-1:0]  alu_out_hi_q, alu_out_hi_d;
  logic           zero_q, zero_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [WL-1:0]  alu_res;
  logic [SHW-1:0] var_amt;
  logic [WL:0]    mul_sum;
`ifdef MCALU_DIV_EN
  logic           divzero_q, divzero_d;
  logic [WL:0]    div_shift;
  logic [WL:0]    div_diff;
  logic           div_fit;
`endif

  assign var_amt = ALUIn1[SHW-1:0];

  always_comb begin
    alu_res = '0;
    case (ALUsel)
      OP_AND:  alu_res = ALUIn1 & ALUIn2;
      OP_OR:   alu_res = ALUIn1 | ALUIn2;
      OP_ADD:  alu_res = ALUIn1 + ALUIn2;
      OP_SUB:  alu_res = ALUIn1 - ALUIn2;
      OP_SLL:  alu_res = ALUIn2 << shamt;
      OP_SRL:  alu_res = ALUIn2 >> shamt;
      OP_SRA:  alu_res = $signed(ALUIn2) >>> shamt;
      OP_SLLV: alu_res = ALUIn2 << var_amt;
      OP_SRLV: alu_res = ALUIn2 >> var_amt;
      OP_SRAV: alu_res = $signed(ALUIn2) >>> var_amt;
      OP_SLTU: alu_res = {{(WL-1){1'b0}}, (ALUIn1 < ALUIn2)};
      OP_SLT:  alu_res = {{(WL-1){1'b0}}, ($signed(ALUIn1) < $signed(ALUIn2))};
      default: alu_res = '0;
    endcase
  end

  // One shift-add step: add the multiplicand when the current multiplier
  // bit is set, then shift the whole {hi,lo} pair right by one.
  assign mul_sum = {1'b0, work_hi_q} + (work_lo_q[0] ? {1'b0, op_q} : '0);

`ifdef MCALU_DIV_EN
  // One restoring step: bring the next dividend bit into the remainder and
  // subtract the divisor if it fits.
  assign div_shift = {work_hi_q, work_lo_q[WL-1]};
  assign div_diff  = div_shift - {1'b0, op_q};
  assign div_fit   = (div_shift >= {1'b0, op_q});
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    op_d         = op_q;
    work_hi_d    = work_hi_q;
    work_lo_d    = work_lo_q;
    alu_out_d    = alu_out_q;
    alu_out_hi_d = alu_out_hi_q;
    zero_d       = zero_q;
    busy_d       = 1'b0;
    done_d       = 1'b0;
`ifdef MCALU_DIV_EN
    divzero_d    = divzero_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          cnt_d = '0;
`ifdef MCALU_DIV_EN
          divzero_d = 1'b0;
`endif
          if (ALUsel == OP_MULU) begin
            state_d   = S_MUL;
            op_d      = ALUIn1;
            work_hi_d = '0;
            work_lo_d = ALUIn2;
            busy_d    = 1'b1;
`ifdef MCALU_DIV_EN
          end else if (ALUsel == OP_DIVU && ALUIn2 == '0) begin
            state_d      = S_DONE;
            alu_out_d    = '1;
            alu_out_hi_d = ALUIn1;
            zero_d       = 1'b0;
            divzero_d    = 1'b1;
            done_d       = 1'b1;
          end else if (ALUsel == OP_DIVU) begin
            state_d   = S_DIV;
            op_d      = ALUIn2;
            work_hi_d = '0;
            work_lo_d = ALUIn1;
            busy_d    = 1'b1;
`endif
          end else begin
            state_d      = S_DONE;
            alu_out_d    = alu_res;
            alu_out_hi_d = '0;
            zero_d       = (alu_res == '0);
            done_d       = 1'b1;
          end
        end
      end
      S_MUL: begin
        work_hi_d = mul_sum[WL:1];
        work_lo_d = {mul_sum[0], work_lo_q[WL-1:1]};
        if (cnt_q == CNT_LAST) begin
          state_d      = S_DONE;
          alu_out_d    = work_lo_d;
          alu_out_hi_d = work_hi_d;
          zero_d       = (work_lo_d == '0);
          done_d       = 1'b1;
        end else begin
          cnt_d  = cnt_q + 1'b1;
          busy_d = 1'b1;
        end
      end
`ifdef MCALU_DIV_EN
      S_DIV: begin
        work_hi_d = div_fit ? div_diff[WL-1:0] : div_shift[WL-1:0];
        work_lo_d = {work_lo_q[WL-2:0], div_fit};
        if (cnt_q == CNT_LAST) begin
          state_d      = S_DONE;
          alu_out_d    = work_lo_d;
          alu_out_hi_d = work_hi_d;
          zero_d       = (work_lo_d == '0);
          done_d       = 1'b1;
        end else begin
          cnt_d  = cnt_q + 1'b1;
          busy_d = 1'b1;
        end
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      op_q         <= '0;
      work_hi_q    <= '0;
      work_lo_q    <= '0;
      alu_out_q    <= '0;
      alu_out_hi_q <= '0;
      zero_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
`ifdef MCALU_DIV_EN
      divzero_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      op_q         <= op_d;
      work_hi_q    <= work_hi_d;
      work_lo_q    <= work_lo_d;
      alu_out_q    <= alu_out_d;
      alu_out_hi_q <= alu_out_hi_d;
      zero_q       <= zero_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
`ifdef MCALU_DIV_EN
      divzero_q    <= divzero_d;
`endif
    end
  end

  assign ALUOut   = alu_out_q;
  assign ALUOutHi = alu_out_hi_q;
  assign Zero     = zero_q;
  assign busy     = busy_q;
  assign done     = done_q;
`ifdef MCALU_DIV_EN
  assign divzero  = divzero_q;
`else
  assign divzero  = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_alu.sv
module tb_multicycle_alu;

  logic        clk;
  logic        rst;
  logic        start;
  logic [3:0]  ALUsel;
  logic [31:0] ALUIn1;
  logic [31:0] ALUIn2;
  logic [4:0]  shamt;
  logic [31:0] ALUOut;
  logic [31:0] ALUOutHi;
  logic        Zero;
  logic        divzero;
  logic        busy;
  logic        done;

  int n_vec = 0;
  int n_err = 0;

  multicycle_alu #(.WL(32), .SHW(5), .SEL(4)) dut (
    .clk(clk), .rst(rst), .start(start), .ALUsel(ALUsel),
    .ALUIn1(ALUIn1), .ALUIn2(ALUIn2), .shamt(shamt),
    .ALUOut(ALUOut), .ALUOutHi(ALUOutHi), .Zero(Zero),
    .divzero(divzero), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called 1 time unit after a rising edge with the FSM in IDLE. Returns 1
  // time unit after the start edge, with operands scrambled so a design that
  // fails to latch them gives a wrong answer.
  task automatic issue(input logic [3:0] sel, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] sh);
    ALUsel = sel; ALUIn1 = a; ALUIn2 = b; shamt = sh; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; ALUIn1 = ~a; ALUIn2 = ~b; shamt = ~sh; ALUsel = 4'b0000;
  endtask

  task automatic step;
    @(posedge clk); #1;
  endtask

  // Waits for done after a multicycle issue; cycle 1 is the one right after
  // the start edge. Optionally pulses start (ADD) during cycle 5.
  task automatic run_multi(input bit inject, output int lat, output int busy_cnt);
    lat = 0;
    busy_cnt = 0;
    for (int k = 1; k <= 40; k++) begin
      if (busy) busy_cnt++;
      if (done) begin
        lat = k;
        break;
      end
      if (inject && k == 5) begin
        start = 1'b1; ALUsel = 4'b0010; ALUIn1 = 32'd1; ALUIn2 = 32'd1;
      end else begin
        start = 1'b0;
      end
      step();
    end
    start = 1'b0;
  endtask

  int lat, bcnt;

  initial begin
    rst = 1'b1; start = 1'b0; ALUsel = '0; ALUIn1 = '0; ALUIn2 = '0; shamt = '0;
    #12;
    chk("reset_outs", {ALUOut, ALUOutHi}, 64'h0);
    chk("reset_flags", {60'h0, Zero, divzero, busy, done}, 64'h0);
    @(negedge clk); rst = 1'b0;
    step();

    // SUB 7-7, then a start held into DONE must be ignored
    issue(4'b0110, 32'd7, 32'd7, 5'd0);
    chk("sub_done", {63'h0, done}, 64'h1);
    chk("sub_out", {ALUOutHi, ALUOut}, 64'h0);
    chk("sub_zero", {63'h0, Zero}, 64'h1);
    start = 1'b1; ALUsel = 4'b0010; ALUIn1 = 32'd1; ALUIn2 = 32'd1;
    step();
    start = 1'b0;
    chk("done_pulse", {62'h0, done, busy}, 64'h0);
    chk("start_in_done_ignored", {32'h0, ALUOut}, 64'h0);

    issue(4'b1101, 32'hFFFF_FFFF, 32'd1, 5'd0);
    chk("slt", {ALUOutHi, ALUOut}, 64'h1);
    chk("slt_zero", {63'h0, Zero}, 64'h0);
    step();
    issue(4'b0111, 32'hFFFF_FFFF, 32'd1, 5'd0);
    chk("sltu", {ALUOutHi, ALUOut}, 64'h0);
    chk("sltu_zero", {63'h0, Zero}, 64'h1);
    step();
    issue(4'b0101, 32'h0, 32'h8000_0000, 5'd4);
    chk("sra_imm", {32'h0, ALUOut}, 64'hF800_0000);
    step();
    issue(4'b1010, 32'd36, 32'h8000_0000, 5'd0);
    chk("sra_var", {32'h0, ALUOut}, 64'hF800_0000);
    step();
    issue(4'b0011, 32'h0, 32'h1, 5'd31);
    chk("sll_imm", {32'h0, ALUOut}, 64'h8000_0000);
    step();
    issue(4'b0100, 32'h0, 32'h8000_0000, 5'd31);
    chk("srl_imm", {32'h0, ALUOut}, 64'h1);
    step();
    issue(4'b1001, 32'd4, 32'hF0, 5'd0);
    chk("srl_var", {32'h0, ALUOut}, 64'hF);
    step();
    issue(4'b1000, 32'd8, 32'h1, 5'd0);
    chk("sll_var", {32'h0, ALUOut}, 64'h100);
    step();
    issue(4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0);
    chk("and", {32'h0, ALUOut}, 64'hF000_F000);
    step();
    issue(4'b0001, 32'hF0F0_F0F0, 32'h0F00_0F00, 5'd0);
    chk("or", {32'h0, ALUOut}, 64'hFFF0_FFF0);
    step();
    issue(4'b0010, 32'hFFFF_FFFF, 32'd1, 5'd0);
    chk("add_wrap", {31'h0, Zero, ALUOut}, 64'h1_0000_0000);
    step();
    issue(4'b1111, 32'd5, 32'd6, 5'd3);
    chk("unknown_op", {31'h0, Zero, ALUOut}, 64'h1_0000_0000);
    step();

    // Leave a known nonzero result to check hold during MUL
    issue(4'b0010, 32'd40, 32'd2, 5'd0);
    step();
    issue(4'b1011, 32'hFFFF_FFFF, 32'd2, 5'd0);
    chk("mul_hold", {ALUOutHi, ALUOut}, 64'd42);
    run_multi(1'b1, lat, bcnt);
    chk("mul_latency", lat, 64'd33);
    chk("mul_busy_cycles", bcnt, 64'd32);
    chk("mul_result", {ALUOutHi, ALUOut}, 64'h1_FFFF_FFFE);
    chk("mul_zero", {63'h0, Zero}, 64'h0);
    step();
    chk("mul_idle", {62'h0, busy, done}, 64'h0);

    issue(4'b1011, 32'h0001_0000, 32'h0001_0000, 5'd0);
    run_multi(1'b0, lat, bcnt);
    chk("mul2_result", {ALUOutHi, ALUOut}, 64'h1_0000_0000);
    chk("mul2_zero", {63'h0, Zero}, 64'h1);
    step();

    // Reset during MUL at cycle 10
    issue(4'b1011, 32'd3, 32'd5, 5'd0);
    repeat (9) step();
    chk("pre_reset_busy", {63'h0, busy}, 64'h1);
    rst = 1'b1;
    #1;
    chk("midrst_outs", {ALUOut, ALUOutHi}, 64'h0);
    chk("midrst_flags", {60'h0, Zero, divzero, busy, done}, 64'h0);
    @(negedge clk); rst = 1'b0;
    step();
    chk("after_rst_idle", {62'h0, busy, done}, 64'h0);
    issue(4'b0010, 32'd2, 32'd3, 5'd0);
    chk("add_after_rst", {31'h0, done, ALUOut}, 64'h1_0000_0005);
    step();

`ifdef MCALU_DIV_EN
    issue(4'b1100, 32'd100, 32'd7, 5'd0);
    run_multi(1'b0, lat, bcnt);
    chk("div_latency", lat, 64'd33);
    chk("div_result", {ALUOutHi, ALUOut}, {32'd2, 32'd14});
    chk("div_divzero", {63'h0, divzero}, 64'h0);
    step();
    issue(4'b1100, 32'd100, 32'd0, 5'd0);
    chk("div0_done", {62'h0, done, divzero}, 64'h3);
    chk("div0_result", {ALUOutHi, ALUOut}, {32'd100, 32'hFFFF_FFFF});
    step();
    issue(4'b0010, 32'd1, 32'd1, 5'd0);
    chk("divzero_clear", {63'h0, divzero}, 64'h0);
    step();
`else
    issue(4'b1100, 32'd100, 32'd7, 5'd0);
    chk("divu_absent_done", {61'h0, done, busy, divzero}, 64'h4);
    chk("divu_absent_out", {31'h0, Zero, ALUOut}, 64'h1_0000_0000);
    step();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
